// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory read port plus the IF/ID handoff to decode.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_stage_if #(
   parameter int PC_W = 64
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            imem_rvalid;
   logic [31:0]     id_instr;
   logic [PC_W-1:0] id_pc;
   logic            id_valid;
   logic            id_stall;
   logic            br_taken;
   logic            uncond_br;

   modport master (
      output imem_req, imem_addr, id_instr, id_pc, id_valid,
      input  imem_ready, imem_rdata, imem_rvalid, id_stall, br_taken, uncond_br
   );

   modport slave (
      input  imem_req, imem_addr, id_instr, id_pc, id_valid,
      output imem_ready, imem_rdata, imem_rvalid, id_stall, br_taken, uncond_br
   );
endinterface

// File: rtl/instr_fetch_stage.sv
// LEGv8 fetch stage: one outstanding imem read, IF/ID register with a one-entry skid,
// and branch redirect computed from the instruction held in IF/ID.
//
// state | meaning
// IDLE  | first cycle after reset release
// FETCH | request pc from imem until accepted
// WAIT  | request outstanding, waiting for imem_rvalid (drop discards it)
// HOLD  | response parked in skid until IF/ID is consumed
module instr_fetch_stage #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 reset_n,
   instr_fetch_stage_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]      state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] req_pc, req_pc_nxt;
   logic            drop, drop_nxt;
   logic [31:0]     skid_instr, skid_instr_nxt;
   logic [PC_W-1:0] skid_pc, skid_pc_nxt;
   logic            skid_valid, skid_valid_nxt;
   logic [31:0]     id_instr_q, id_instr_nxt;
   logic [PC_W-1:0] id_pc_q, id_pc_nxt;
   logic            id_valid_q, id_valid_nxt;

   logic            consume;
   logic            redirect;
   logic            issue;
   logic            rsp;
   logic [PC_W-1:0] off_imm26;
   logic [PC_W-1:0] off_imm19;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] req_pc_inc;

   assign consume    = id_valid_q & ~bus.id_stall;
   assign redirect   = consume & bus.br_taken;
   assign issue      = (state == S_FETCH) & bus.imem_ready;
   assign rsp        = (state == S_WAIT) & bus.imem_rvalid;
   assign req_pc_inc = req_pc + PC_W'(4);

   // word offsets scaled to bytes, sign-extended to the full PC width
   assign off_imm26  = {{(PC_W-28){id_instr_q[25]}}, id_instr_q[25:0], 2'b00};
   assign off_imm19  = {{(PC_W-21){id_instr_q[23]}}, id_instr_q[23:5], 2'b00};
   assign br_target  = id_pc_q + (bus.uncond_br ? off_imm26 : off_imm19);

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_pc_nxt     = req_pc;
      drop_nxt       = drop;
      skid_instr_nxt = skid_instr;
      skid_pc_nxt    = skid_pc;
      skid_valid_nxt = skid_valid;
      id_instr_nxt   = id_instr_q;
      id_pc_nxt      = id_pc_q;
      id_valid_nxt   = id_valid_q & ~consume;

      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            if (issue) begin
               state_nxt  = S_WAIT;
               req_pc_nxt = pc;
            end
         end
         S_WAIT: begin
            if (rsp) begin
               if (drop) begin
                  drop_nxt  = 1'b0;
                  state_nxt = S_FETCH;
               end else if (!id_valid_q || consume) begin
                  id_instr_nxt = bus.imem_rdata;
                  id_pc_nxt    = req_pc;
                  id_valid_nxt = 1'b1;
                  pc_nxt       = req_pc_inc;
                  state_nxt    = S_FETCH;
               end else begin
                  skid_instr_nxt = bus.imem_rdata;
                  skid_pc_nxt    = req_pc;
                  skid_valid_nxt = 1'b1;
                  pc_nxt         = req_pc_inc;
                  state_nxt      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (consume) begin
               id_instr_nxt   = skid_instr;
               id_pc_nxt      = skid_pc;
               id_valid_nxt   = 1'b1;
               skid_valid_nxt = 1'b0;
               state_nxt      = S_FETCH;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // redirect overrides any response load decided above
      if (redirect) begin
         pc_nxt         = br_target;
         id_valid_nxt   = 1'b0;
         skid_valid_nxt = 1'b0;
         case (state)
            S_FETCH: drop_nxt = issue;
            S_WAIT: begin
               drop_nxt  = ~rsp;
               state_nxt = rsp ? S_FETCH : S_WAIT;
            end
            S_HOLD:  state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         req_pc     <= '0;
         drop       <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         skid_valid <= 1'b0;
         id_instr_q <= '0;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         req_pc     <= req_pc_nxt;
         drop       <= drop_nxt;
         skid_instr <= skid_instr_nxt;
         skid_pc    <= skid_pc_nxt;
         skid_valid <= skid_valid_nxt;
         id_instr_q <= id_instr_nxt;
         id_pc_q    <= id_pc_nxt;
         id_valid_q <= id_valid_nxt;
      end
   end

   assign bus.imem_req  = (state == S_FETCH);
   assign bus.imem_addr = pc;
   assign bus.id_instr  = id_instr_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_valid  = id_valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios then randomized traffic, checked against
// a queue-based model (in-flight requests + IF/ID/skid contents as an ordered buffer).
module tb_instr_fetch_stage;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_stage_if #(.PC_W(64)) bus ();

   instr_fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {logic [63:0] addr; bit drop;} fl_t;
   typedef struct {logic [31:0] instr; logic [63:0] pc;} ent_t;

   fl_t         inflight[$];
   ent_t        idq[$];
   logic [63:0] m_pc;
   bit          started;

   logic [31:0] ovr [logic [63:0]];
   int          mem_cnt   = -1;
   logic [63:0] mem_addr  = '0;
   int          lat_fixed = 1;
   logic [63:0] iss_log[$];

   bit          last_req, last_idv;
   logic [63:0] last_addr, last_idpc;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (ovr.exists(a)) return ovr[a];
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit stall, input bit br, input bit unc, input bit ready);
      bit          rv, exp_req, consume, redirect, issue;
      ent_t        f;
      fl_t         e;
      logic [63:0] off, tgt;
      rv               = (mem_cnt == 0);
      bus.id_stall     = stall;
      bus.br_taken     = br;
      bus.uncond_br    = unc;
      bus.imem_ready   = ready;
      bus.imem_rvalid  = rv;
      bus.imem_rdata   = rv ? mem_word(mem_addr) : $urandom();
      @(negedge clk);
      exp_req = started && inflight.size() == 0 && idq.size() < 2;
      chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
      chk("id_valid", 64'(bus.id_valid), 64'(idq.size() > 0));
      if (idq.size() > 0) begin
         chk("id_instr", 64'(bus.id_instr), 64'(idq[0].instr));
         chk("id_pc", bus.id_pc, idq[0].pc);
      end
      last_req  = bus.imem_req;
      last_addr = bus.imem_addr;
      last_idv  = bus.id_valid;
      last_idpc = bus.id_pc;

      consume  = idq.size() > 0 && !stall;
      redirect = consume && br;
      issue    = exp_req && ready;
      if (redirect) begin
         f   = idq[0];
         off = unc ? ({{38{f.instr[25]}}, f.instr[25:0]} << 2)
                   : ({{45{f.instr[23]}}, f.instr[23:5]} << 2);
         tgt = f.pc + off;
         idq.delete();
         foreach (inflight[i]) inflight[i].drop = 1'b1;
         if (rv && inflight.size() > 0) void'(inflight.pop_front());
         if (issue) inflight.push_back(fl_t'{m_pc, 1'b1});
         m_pc = tgt;
      end else begin
         if (consume) void'(idq.pop_front());
         if (rv && inflight.size() > 0) begin
            e = inflight.pop_front();
            if (!e.drop) begin
               idq.push_back(ent_t'{mem_word(e.addr), e.addr});
               m_pc = e.addr + 64'd4;
            end
         end
         if (issue) inflight.push_back(fl_t'{m_pc, 1'b0});
      end
      started = 1'b1;

      if (rv) mem_cnt = -1;
      else if (mem_cnt > 0) mem_cnt--;
      if (bus.imem_req && ready) begin
         mem_addr = bus.imem_addr;
         mem_cnt  = (lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 3))) - 1;
         iss_log.push_back(bus.imem_addr);
      end
      @(posedge clk);
      #1;
   endtask

   // late >= 0 leaves a stale response arriving that many cycles after release
   task automatic do_reset(input int late);
      reset_n         = 1'b0;
      bus.id_stall    = 1'b0;
      bus.br_taken    = 1'b0;
      bus.uncond_br   = 1'b0;
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      #2;
      chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
      chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
      chk("rst_id_pc", bus.id_pc, 64'd0);
      chk("rst_id_instr", 64'(bus.id_instr), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      inflight.delete();
      idq.delete();
      iss_log.delete();
      m_pc    = 64'h0;
      started = 1'b0;
      mem_cnt = late;
   endtask

   task automatic run_until(input logic [63:0] pc);
      bit hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         hit = idq.size() > 0 && idq[0].pc == pc;
      end
      chk("reach_id_pc", 64'(hit), 64'd1);
   endtask

   task automatic wait_req(input string tag, input logic [63:0] exp_addr);
      bit got = 1'b0;
      bit saw = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         saw = saw | last_idv;
         got = last_req;
      end
      chk({tag, "_req_seen"}, 64'(got), 64'd1);
      chk({tag, "_addr"}, last_addr, exp_addr);
      chk({tag, "_no_id_valid"}, 64'(saw), 64'd0);
   endtask

   initial begin
      ovr[64'h01C] = 32'h1400_0039;   // B -> 0x100
      ovr[64'h100] = 32'h1400_0003;   // B -> 0x10C
      ovr[64'h10C] = 32'h1400_003D;   // B -> 0x200
      ovr[64'h200] = 32'hB4FF_FFC0;   // CBZ imm19=-2 -> 0x1F8
      ovr[64'h1F8] = 32'h1400_0010;   // B -> 0x238
      ovr[64'h238] = 32'h1400_0010;   // B -> 0x278 (never taken: stalled)

      #1;
      do_reset(-1);

      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("seq_addr0", iss_log[0], 64'h0);
      chk("seq_addr1", iss_log[1], 64'h4);
      chk("seq_addr2", iss_log[2], 64'h8);

      run_until(64'h10);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("stall_hold_req", 64'(last_req), 64'd0);
      chk("stall_hold_idpc", last_idpc, 64'h10);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("skid_idpc", last_idpc, 64'h14);
      chk("skid_next_req", 64'(last_req), 64'd1);
      chk("skid_next_addr", last_addr, 64'h18);

      run_until(64'h1C);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      wait_req("b_to_100", 64'h100);
      run_until(64'h100);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      wait_req("b_imm26", 64'h10C);
      run_until(64'h10C);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      wait_req("b_to_200", 64'h200);
      run_until(64'h200);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      lat_fixed = 2;
      wait_req("cbz_imm19", 64'h1F8);

      run_until(64'h1F8);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      wait_req("rsp_redirect", 64'h238);

      run_until(64'h238);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("stalled_br_idpc", last_idpc, 64'h23C);
      chk("stalled_br_idv", 64'(last_idv), 64'd1);
      chk("stalled_br_req", 64'(last_req), 64'd1);
      chk("stalled_br_addr", last_addr, 64'h240);

      do_reset(1);
      wait_req("rst_restart", 64'h0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

      lat_fixed = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 900 == 899) do_reset(int'($urandom_range(0, 2)));
         step($urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
